// File: rtl/rf_wb_queue.sv
// Write-back queue between a dual-issue result bus and a two-port register file.
// Results commit strictly in program order, up to two per cycle.
module rf_wb_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        flush,
    input  logic        stall,
    input  logic        in_valid0,
    input  logic        in_wen0,
    input  logic [4:0]  in_rd0,
    input  logic [31:0] in_data0,
    input  logic        in_valid1,
    input  logic        in_wen1,
    input  logic [4:0]  in_rd1,
    input  logic [31:0] in_data1,
    output logic        in_ready,
    output logic        we1,
    output logic [4:0]  waddr1,
    output logic [31:0] wdata1,
    output logic        we2,
    output logic [4:0]  waddr2,
    output logic [31:0] wdata2,
    input  logic [4:0]  qaddr1,
    input  logic [4:0]  qaddr2,
    input  logic [4:0]  qaddr3,
    input  logic [4:0]  qaddr4,
    output logic        qpend1,
    output logic        qpend2,
    output logic        qpend3,
    output logic        qpend4,
    output logic [3:0]  count,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic        mem_wen  [DEPTH];
    logic [4:0]  mem_rd   [DEPTH];
    logic [31:0] mem_data [DEPTH];

    logic             push0;
    logic             push1;
    logic [PTR_W-1:0] slot1_idx;
    logic [CNT_W-1:0] n_push;
    logic [CNT_W-1:0] n_pop;
    logic             pop_ok;
    logic             pop1;
    logic             pop2;
    logic [PTR_W-1:0] head_next1;
    logic             wr1;
    logic             wr2;
    logic             waw;
    logic [DEPTH-1:0] entry_valid;

    assign in_ready = (cnt <= CNT_W'(DEPTH - 2));
    assign count    = 4'(cnt);
    assign empty    = (cnt == '0);

    // Pop decisions use the count held at the start of the cycle, so a
    // result pushed in this cycle can never leave in the same cycle.
    always_comb begin
        push0      = in_ready && in_valid0;
        push1      = in_ready && in_valid1;
        slot1_idx  = in_valid0 ? tail + PTR_W'(1) : tail;
        n_push     = CNT_W'(push0) + CNT_W'(push1);
        pop_ok     = !stall && !flush;
        pop1       = pop_ok && (cnt != '0);
        pop2       = pop_ok && (cnt >= CNT_W'(2));
        n_pop      = CNT_W'(pop1) + CNT_W'(pop2);
        head_next1 = head + PTR_W'(1);
        wr1        = pop1 && mem_wen[head] && (mem_rd[head] != 5'd0);
        wr2        = pop2 && mem_wen[head_next1] && (mem_rd[head_next1] != 5'd0);
        waw        = wr1 && wr2 && (mem_rd[head] == mem_rd[head_next1]);
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
            we1    <= 1'b0;
            we2    <= 1'b0;
            waddr1 <= '0;
            wdata1 <= '0;
            waddr2 <= '0;
            wdata2 <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            we1  <= 1'b0;
            we2  <= 1'b0;
        end else begin
            head <= head + PTR_W'(n_pop);
            tail <= tail + PTR_W'(n_push);
            cnt  <= cnt + n_push - n_pop;
            // On a same-register pair only the younger write reaches the regfile.
            we1  <= wr1 && !waw;
            we2  <= wr2;
            if (pop1) begin
                waddr1 <= mem_rd[head];
                wdata1 <= mem_data[head];
            end
            if (pop2) begin
                waddr2 <= mem_rd[head_next1];
                wdata2 <= mem_data[head_next1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aresetn && !flush) begin
            if (push0) begin
                mem_wen[tail]  <= in_wen0;
                mem_rd[tail]   <= in_rd0;
                mem_data[tail] <= in_data0;
            end
            if (push1) begin
                mem_wen[slot1_idx]  <= in_wen1;
                mem_rd[slot1_idx]   <= in_rd1;
                mem_data[slot1_idx] <= in_data1;
            end
        end
    end

    // An entry is live when its distance from head is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = (CNT_W'(PTR_W'(i) - head) < cnt);
        end
    end

    // Hazard query covers queued entries only; the regfile bypasses the
    // registered commit outputs itself.
    always_comb begin
        qpend1 = 1'b0;
        qpend2 = 1'b0;
        qpend3 = 1'b0;
        qpend4 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && mem_wen[i]) begin
                if ((qaddr1 != 5'd0) && (mem_rd[i] == qaddr1)) qpend1 = 1'b1;
                if ((qaddr2 != 5'd0) && (mem_rd[i] == qaddr2)) qpend2 = 1'b1;
                if ((qaddr3 != 5'd0) && (mem_rd[i] == qaddr3)) qpend3 = 1'b1;
                if ((qaddr4 != 5'd0) && (mem_rd[i] == qaddr4)) qpend4 = 1'b1;
            end
        end
    end

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter: DEPTH, 8, queue entries; power of two, >= 4.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 aresetn  in  1  reset, synchronous, active-low.
REQ-004 flush  in  1  discard all queued results.
REQ-005 stall  in  1  inhibit commit (pop) this cycle.
REQ-006 in_valid0, in_wen0, in_rd0[4:0], in_data0[31:0]  in  result slot 0 (older).
REQ-007 in_valid1, in_wen1, in_rd1[4:0], in_data1[31:0]  in  result slot 1 (younger).
REQ-008 in_ready  out  1  queue can accept two results this cycle.
REQ-009 we1, waddr1[4:0], wdata1[31:0]  out  regfile write port 1 (older commit).
REQ-010 we2, waddr2[4:0], wdata2[31:0]  out  regfile write port 2 (younger commit).
REQ-011 qaddr1..qaddr4[4:0]  in  hazard-query register addresses.
REQ-012 qpend1..qpend4  out  1 each  queued uncommitted write exists for qaddrK.
REQ-013 count[3:0]  out  number of valid entries; empty  out  1  count==0.

Function
REQ-014 Circular queue: head/tail pointers, log2(DEPTH) bits, wrap modulo DEPTH; entry = {wen, rd, data}.
REQ-015 in_ready = (count <= DEPTH-2), combinational from registered count.
REQ-016 Push when in_ready: in_valid0 writes at tail; in_valid1 writes at tail+1 if in_valid0 else at tail; tail advances by pushes.
REQ-017 Pushes with in_ready=0 ignored; producer holds data (valid/ready handshake).
REQ-018 Pop when !stall && !flush: pop n = min(count, 2) using count at cycle start; entries pushed this cycle never popped same cycle.
REQ-019 Commit outputs registered: popped head -> port1, head+1 -> port2, valid after the popping edge.
REQ-020 weK = popped && entry.wen && entry.rd != 0; waddrK/wdataK = entry fields when popped, else hold previous.
REQ-021 n==1 -> we2=0; n==0 or stall -> we1=we2=0.
REQ-022 WAW: both popped, both write-enabled, same nonzero rd -> we1=0, we2=1 (younger wins).
REQ-023 Entries with wen=0 or rd=0 consume a pop slot, produce no write.
REQ-024 count_next = count + pushes - pops; never exceeds DEPTH, never underflows.
REQ-025 Minimum latency: result accepted at edge N -> on write port after edge N+1.
REQ-026 qpendK = (qaddrK != 0) && any valid queue entry has wen && rd==qaddrK; combinational; registered commit outputs excluded (regfile bypasses them).
REQ-027 flush priority over push and pop: next edge head=tail=0, count=0, we1=we2=0; same-cycle pushes dropped.
REQ-028 stall with push: pushes still accepted; queue contents and order preserved.
REQ-029 Commit order strictly program order: slot0 before slot1, earlier cycles before later.

Reset
REQ-030 aresetn=0 at edge: head=tail=0, count=0, empty=1, we1=we2=0, waddr1/2=0, wdata1/2=0; in_ready=1 after.
REQ-031 Reset mid-operation discards all entries; no write port assertion on the following cycle.
REQ-032 Reset priority over flush, stall, push.

Verification
REQ-033 Push {wen=1,rd=5,0xAAAA0001} and {wen=1,rd=6,0xBBBB0002} same cycle -> next cycle we1=1/waddr1=5, we2=1/waddr2=6.
REQ-034 Fill with stall=1: 7 entries -> in_ready=0, count=7; 8th single push rejected; release stall -> 2 commits/cycle in order, count 7,5,3,1,0.
REQ-035 Pop pair both rd=9 (0x11, 0x22) -> we1=0, we2=1, waddr2=9, wdata2=0x22.
REQ-036 Queue rd=3 wen=1 entry, stall=1, qaddr2=3 -> qpend2=1; qaddr1=0 -> qpend1=0; after commit -> qpend2=0.
REQ-037 count=4 plus push, flush=1 -> next cycle count=0, empty=1, we1=we2=0; no dropped entry ever appears on write ports.
REQ-038 Entry wen=0 rd=7 followed by wen=1 rd=0 -> both pop, we1=we2=0, count decrements by 2.
